mips_instr_encoder: RTL

- Inverse of the P4 control-unit decoder: takes an instruction kind plus register/immediate fields and produces the 32-bit MIPS machine word.
- Supported set matches the decoder: add, sub, ori, lw, sw, beq, lui, jal, jr, sll, nop.
- Encoded words are buffered in a small FIFO and streamed out with a word address (PC-style, from BASE_ADDR).
- Used by testbenches and by the instruction-memory loader to build programs in hardware.

---
 rtl/mips_instr_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs kind + fields into a 32-bit word, buffers it in a FIFO and tags it with a PC-style address.
// Optional build macro ENC_ILLEGAL_TRAP_EN: illegal kinds are dropped and raise err instead of being encoded as nop.
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_j_address,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] instr_count,
  output logic        err
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [3:0] K_ADD = 4'd0, K_SUB = 4'd1, K_ORI = 4'd2, K_LW  = 4'd3,
                         K_SW  = 4'd4, K_BEQ = 4'd5, K_LUI = 4'd6, K_JAL = 4'd7,
                         K_JR  = 4'd8, K_SLL = 4'd9, K_NOP = 4'd10;

  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [31:0] addr_mem  [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   next_addr_q, next_addr_d;
  logic [15:0]   instr_count_q, instr_count_d;
  logic          err_q, err_d;
  logic [31:0]   last_instr_q, last_instr_d;
  logic [31:0]   last_addr_q, last_addr_d;

  logic        full, empty, push, pop, illegal, wr_en, err_set;
  logic [31:0] enc_word;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign illegal   = (in_kind > K_NOP);

`ifdef ENC_ILLEGAL_TRAP_EN
  assign wr_en   = push && !illegal;
  assign err_set = push && illegal;
`else
  assign wr_en   = push;
  assign err_set = 1'b0;
`endif

  // Unused fields are forced to zero; illegal kinds fall through to 0 (nop).
  always_comb begin
    enc_word = 32'h0;
    case (in_kind)
      K_ADD: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      K_SUB: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      K_ORI: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      K_LW:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      K_LUI: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      K_JAL: enc_word = {6'b000011, in_j_address};
      K_JR:  enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
      K_SLL: enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000000};
      default: enc_word = 32'h0;
    endcase
  end

  // The head shows the FIFO entry when present, otherwise whatever was last shown.
  assign out_instr   = empty ? last_instr_q : instr_mem[rd_ptr_q];
  assign out_addr    = empty ? last_addr_q  : addr_mem[rd_ptr_q];
  assign instr_count = instr_count_q;
  assign err         = err_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    next_addr_d   = next_addr_q;
    instr_count_d = instr_count_q;
    err_d         = err_q | err_set;
    last_instr_d  = out_instr;
    last_addr_d   = out_addr;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      next_addr_d   = BASE_ADDR;
      instr_count_d = 16'h0;
    end else begin
      if (wr_en) begin
        wr_ptr_d    = wr_ptr_q + PW'(1);
        next_addr_d = next_addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      next_addr_q   <= BASE_ADDR;
      instr_count_q <= 16'h0;
      err_q         <= 1'b0;
      last_instr_q  <= 32'h0;
      last_addr_q   <= BASE_ADDR;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      next_addr_q   <= next_addr_d;
      instr_count_q <= instr_count_d;
      err_q         <= err_d;
      last_instr_q  <= last_instr_d;
      last_addr_q   <= last_addr_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      instr_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q]  <= next_addr_q;
    end
  end

endmodule
